truth_table_scanner: RTL and testbench

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

---
 rtl/truth_table_scanner.sv | 102 ++++++++++
 tb/tb_truth_table_scanner.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// Drives all 8 {x,y,z} vectors into two implementations and captures both truth tables.
// Optional build macro TT_EARLY_STOP_EN: end the scan at the first mismatching vector.
module truth_table_scanner #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       s_a,
  input  logic       s_b,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_a,
  output logic [7:0] table_b,
  output logic       equal,
  output logic [3:0] mismatch_cnt,
  output logic [2:0] first_mm
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [2:0] idx;
  logic [3:0] settle_cnt;
  logic       mm;

  assign mm = s_a ^ s_b;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = DRIVE;
      DRIVE:  if (settle_cnt == 4'd0) state_nxt = SAMPLE;
      SAMPLE: begin
`ifdef TT_EARLY_STOP_EN
        if (mm || idx == 3'd7) state_nxt = FINISH;
        else                   state_nxt = DRIVE;
`else
        if (idx == 3'd7) state_nxt = FINISH;
        else             state_nxt = DRIVE;
`endif
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= 3'd0;
      settle_cnt   <= 4'd0;
      {x, y, z}    <= 3'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      table_a      <= 8'h00;
      table_b      <= 8'h00;
      mismatch_cnt <= 4'd0;
      first_mm     <= 3'd0;
      equal        <= 1'b1;
    end else begin
      state <= state_nxt;
      // busy/done are registered decodes of the state being entered
      busy  <= (state_nxt == DRIVE) || (state_nxt == SAMPLE);
      done  <= (state_nxt == FINISH);
      case (state)
        IDLE: if (start) begin
          idx          <= 3'd0;
          settle_cnt   <= SETTLE_LD;
          {x, y, z}    <= 3'd0;
          table_a      <= 8'h00;
          table_b      <= 8'h00;
          mismatch_cnt <= 4'd0;
          first_mm     <= 3'd0;
        end
        DRIVE: if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        SAMPLE: begin
          table_a[idx] <= s_a;
          table_b[idx] <= s_b;
          if (mm) begin
            mismatch_cnt <= mismatch_cnt + 4'd1;
            if (mismatch_cnt == 4'd0) first_mm <= idx;
          end
          if (state_nxt == DRIVE) begin
            idx        <= idx + 3'd1;
            {x, y, z}  <= idx + 3'd1;
            settle_cnt <= SETTLE_LD;
          end
          // fold in this cycle's compare so equal is valid alongside done
          if (state_nxt == FINISH) equal <= (mismatch_cnt == 4'd0) && !mm;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: SETTLE=1 and SETTLE=3 instances.
module tb_truth_table_scanner;

  logic       clk = 1'b0, rst_n = 1'b0, start1 = 1'b0, start3 = 1'b0;
  logic [1:0] mode_a = 2'd0, mode_b = 2'd0;
  logic       x1, y1, z1, busy1, done1, eq1, sa1, sb1;
  logic [7:0] ta1, tb1;
  logic [3:0] cnt1;
  logic [2:0] fm1;
  logic       x3, y3, z3, busy3, done3, eq3;
  logic [7:0] ta3, tb3;
  logic [3:0] cnt3;
  logic [2:0] fm3;
  int         checks = 0, errors = 0;

  // 0: y^z, 1: constant 0, other: x
  function automatic logic resp(input logic [1:0] m, input logic xi, yi, zi);
    case (m)
      2'd0:    return yi ^ zi;
      2'd1:    return 1'b0;
      default: return xi;
    endcase
  endfunction

  assign sa1 = resp(mode_a, x1, y1, z1);
  assign sb1 = resp(mode_b, x1, y1, z1);

  truth_table_scanner #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .s_a(sa1), .s_b(sb1),
    .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1),
    .table_a(ta1), .table_b(tb1), .equal(eq1), .mismatch_cnt(cnt1), .first_mm(fm1));

  truth_table_scanner #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .s_a(x3), .s_b(x3),
    .x(x3), .y(y3), .z(z3), .busy(busy3), .done(done3),
    .table_a(ta3), .table_b(tb3), .equal(eq3), .mismatch_cnt(cnt3), .first_mm(fm3));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic accept1;
    start1 = 1'b1; tick; start1 = 1'b0;
  endtask

  task automatic wait_done1(output int cyc);
    cyc = 0;
    while (!done1 && cyc < 200) begin tick; cyc++; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tick; tick;
    checks++; if ({x1, y1, z1} !== 3'd0) begin errors++; $display("FAIL reset_xyz got %0d want 0", {x1, y1, z1}); end
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy1, done1); end
    checks++; if (ta1 !== 8'h00 || tb1 !== 8'h00) begin errors++; $display("FAIL reset_tables got %h/%h want 00/00", ta1, tb1); end
    checks++; if (eq1 !== 1'b1 || cnt1 !== 4'd0 || fm1 !== 3'd0) begin errors++; $display("FAIL reset_results got eq=%b cnt=%0d fm=%0d want 1/0/0", eq1, cnt1, fm1); end
    rst_n = 1'b1; tick;
  endtask

  task automatic test_equal;
    int cyc;
    mode_a = 2'd0; mode_b = 2'd0;
    accept1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL equal_busy got %b want 1", busy1); end
    wait_done1(cyc);
    checks++; if (cyc != 16) begin errors++; $display("FAIL equal_latency got %0d want 16", cyc); end
    checks++; if (ta1 !== 8'h66 || tb1 !== 8'h66) begin errors++; $display("FAIL equal_tables got %h/%h want 66/66", ta1, tb1); end
    checks++; if (eq1 !== 1'b1 || cnt1 !== 4'd0 || fm1 !== 3'd0) begin errors++; $display("FAIL equal_results got eq=%b cnt=%0d fm=%0d want 1/0/0", eq1, cnt1, fm1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL equal_busy_finish got %b want 0", busy1); end
    tick;
    checks++; if (done1 !== 1'b0 || {x1, y1, z1} !== 3'd7) begin errors++; $display("FAIL equal_hold got done=%b xyz=%0d want 0/7", done1, {x1, y1, z1}); end
  endtask

  task automatic test_mismatch;
    int cyc;
    mode_a = 2'd0; mode_b = 2'd1;
    accept1;
    wait_done1(cyc);
`ifdef TT_EARLY_STOP_EN
    checks++; if (cyc != 4) begin errors++; $display("FAIL mm_latency got %0d want 4", cyc); end
    checks++; if (ta1 !== 8'h02 || tb1 !== 8'h00) begin errors++; $display("FAIL mm_tables got %h/%h want 02/00", ta1, tb1); end
    checks++; if (cnt1 !== 4'd1) begin errors++; $display("FAIL mm_cnt got %0d want 1", cnt1); end
`else
    checks++; if (cyc != 16) begin errors++; $display("FAIL mm_latency got %0d want 16", cyc); end
    checks++; if (ta1 !== 8'h66 || tb1 !== 8'h00) begin errors++; $display("FAIL mm_tables got %h/%h want 66/00", ta1, tb1); end
    checks++; if (cnt1 !== 4'd4) begin errors++; $display("FAIL mm_cnt got %0d want 4", cnt1); end
`endif
    checks++; if (eq1 !== 1'b0 || fm1 !== 3'd1) begin errors++; $display("FAIL mm_results got eq=%b fm=%0d want 0/1", eq1, fm1); end
    tick; tick;
  endtask

  task automatic test_settle3;
    int ndone = 0;
    start3 = 1'b1; tick; start3 = 1'b0;
    for (int c = 0; c < 32; c++) begin
      checks++; if ({x3, y3, z3} !== 3'(c >> 2) || busy3 !== 1'b1) begin errors++; $display("FAIL s3_vector cycle %0d got xyz=%0d busy=%b want %0d/1", c, {x3, y3, z3}, busy3, c >> 2); end
      if (done3) ndone++;
      tick;
    end
    checks++; if (done3 !== 1'b1 || ndone != 0) begin errors++; $display("FAIL s3_done got done=%b early=%0d want 1/0", done3, ndone); end
    checks++; if (ta3 !== 8'hF0 || tb3 !== 8'hF0 || eq3 !== 1'b1 || cnt3 !== 4'd0 || fm3 !== 3'd0) begin errors++; $display("FAIL s3_results got %h/%h eq=%b cnt=%0d fm=%0d want F0/F0/1/0/0", ta3, tb3, eq3, cnt3, fm3); end
    tick;
  endtask

  task automatic test_restart_ignored;
    int ndone = 0, fc = -1;
    mode_a = 2'd0; mode_b = 2'd0;
    accept1;
    for (int c = 1; c <= 40; c++) begin
      start1 = (c == 7);
      tick;
      if (done1) begin ndone++; if (fc < 0) fc = c; end
    end
    start1 = 1'b0;
    checks++; if (ndone != 1 || fc != 16) begin errors++; $display("FAIL restart_done got n=%0d at=%0d want 1/16", ndone, fc); end
    checks++; if (ta1 !== 8'h66 || tb1 !== 8'h66 || eq1 !== 1'b1 || cnt1 !== 4'd0) begin errors++; $display("FAIL restart_results got %h/%h eq=%b cnt=%0d want 66/66/1/0", ta1, tb1, eq1, cnt1); end
  endtask

  task automatic test_reset_mid;
    int c = 0, ndone = 0, cyc;
    mode_a = 2'd0; mode_b = 2'd0;
    accept1;
    while ({x1, y1, z1} != 3'd5 && c < 50) begin tick; c++; end
    checks++; if (c != 10) begin errors++; $display("FAIL rmid_reach got %0d want 10", c); end
    rst_n = 1'b0; tick; rst_n = 1'b1;
    checks++; if ({x1, y1, z1} !== 3'd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL rmid_ctrl got xyz=%0d busy=%b done=%b want 0/0/0", {x1, y1, z1}, busy1, done1); end
    checks++; if (ta1 !== 8'h00 || tb1 !== 8'h00 || eq1 !== 1'b1 || cnt1 !== 4'd0 || fm1 !== 3'd0) begin errors++; $display("FAIL rmid_results got %h/%h eq=%b cnt=%0d fm=%0d want 00/00/1/0/0", ta1, tb1, eq1, cnt1, fm1); end
    for (int i = 0; i < 20; i++) begin tick; if (done1 || busy1) ndone++; end
    checks++; if (ndone != 0) begin errors++; $display("FAIL rmid_quiet got %0d want 0", ndone); end
    rst_n = 1'b0; start1 = 1'b1; tick; rst_n = 1'b1; start1 = 1'b0;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_over_start got %b want 0", busy1); end
    tick;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_over_start_idle got %b want 0", busy1); end
    accept1;
    wait_done1(cyc);
    checks++; if (cyc != 16 || ta1 !== 8'h66 || tb1 !== 8'h66 || eq1 !== 1'b1) begin errors++; $display("FAIL rmid_rescan got cyc=%0d %h/%h eq=%b want 16/66/66/1", cyc, ta1, tb1, eq1); end
    tick;
  endtask

  task automatic test_back_to_back;
    int nd = 0, d0 = -1, d1 = -1, cyc;
    mode_a = 2'd0; mode_b = 2'd0;
    start1 = 1'b1; tick;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (done1) begin nd++; if (d0 < 0) d0 = c; else if (d1 < 0) d1 = c; end
    end
    start1 = 1'b0;
    checks++; if (nd != 2 || d0 != 16 || d1 != 34) begin errors++; $display("FAIL b2b_done got n=%0d at %0d,%0d want 2 at 16,34", nd, d0, d1); end
    wait_done1(cyc);
    tick; tick;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL b2b_stop got busy=%b want 0", busy1); end
  endtask

  initial begin
    test_reset;
    test_equal;
    test_mismatch;
    test_settle3;
    test_restart_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
